// File: rtl/cpu_pkg.sv
// Shared types and constants for the ARM control sequencer: state encoding,
// condition-code values and NZCV bit positions.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MUL    = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } cpu_state_t;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// ARM condition evaluation: every condition is computed in parallel from NZCV
// and the instruction's condition field selects one of them.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       pass
);

  function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    case (cond)
      COND_EQ: eval_cond = z;
      COND_NE: eval_cond = !z;
      COND_CS: eval_cond = c;
      COND_CC: eval_cond = !c;
      COND_MI: eval_cond = n;
      COND_PL: eval_cond = !n;
      COND_VS: eval_cond = v;
      COND_VC: eval_cond = !v;
      COND_HI: eval_cond = c && !z;
      COND_LS: eval_cond = !c || z;
      COND_GE: eval_cond = (n == v);
      COND_LT: eval_cond = (n != v);
      COND_GT: eval_cond = !z && (n == v);
      COND_LE: eval_cond = z || (n != v);
      COND_AL: eval_cond = 1'b1;
      default: eval_cond = 1'b0;
    endcase
  endfunction

  logic [15:0] pass_table;

  for (genvar gi = 0; gi < 16; gi++) begin : g_cond
    assign pass_table[gi] = eval_cond(4'(gi), i_flags);
  end

  assign pass = pass_table[i_cond];

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: fetch, condition check, then execute / multiply /
// memory / trap, with one-cycle strobes and a retired-instruction counter.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel,
  input  logic [3:0]       i_cond,
  input  logic [3:0]       i_flags,
  input  logic             i_is_mem,
  input  logic             i_is_store,
  input  logic             i_is_branch,
  input  logic             i_is_link,
  input  logic             i_is_mul,
  input  logic             i_is_swi,
  input  logic             i_no_wb,
  input  logic             i_set,
  output logic             o_ir_load,
  output logic             o_pc_inc,
  output logic             o_pc_load,
  output logic             o_alu_en,
  output logic             o_mul_busy,
  output logic             o_rf_we,
  output logic             o_link_we,
  output logic             o_flags_we,
  output logic             o_swi_trap,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_retired
);

  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  cpu_state_t       state_reg, state_next;
  logic [3:0]       mul_cnt_reg, mul_cnt_next;
  logic [CNT_W-1:0] retired_reg;
  logic             retire;
  logic             pass;

  cond_check u_cond_check (
    .i_cond  (i_cond),
    .i_flags (i_flags),
    .pass    (pass)
  );

  always_comb begin
    state_next   = state_reg;
    mul_cnt_next = mul_cnt_reg;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel      = 1'b0;
    o_ir_load    = 1'b0;
    o_pc_inc     = 1'b0;
    o_pc_load    = 1'b0;
    o_alu_en     = 1'b0;
    o_mul_busy   = 1'b0;
    o_rf_we      = 1'b0;
    o_link_we    = 1'b0;
    o_flags_we   = 1'b0;
    o_swi_trap   = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          o_ir_load  = 1'b1;
          o_pc_inc   = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!pass)            state_next = ST_FETCH;
        else if (i_is_swi)    state_next = ST_TRAP;
        else if (i_is_branch) state_next = ST_EXEC;
        else if (i_is_mul) begin
          state_next   = ST_MUL;
          mul_cnt_next = MUL_LAST;
        end
        else if (i_is_mem)    state_next = ST_MEM;
        else                  state_next = ST_EXEC;
      end
      ST_EXEC: begin
        retire     = 1'b1;
        state_next = ST_FETCH;
        // Only branches and data-processing ops reach EXEC.
        if (i_is_branch) begin
          o_pc_load = 1'b1;
          o_link_we = i_is_link;
        end else begin
          o_alu_en   = 1'b1;
          o_rf_we    = !i_no_wb;
          o_flags_we = i_set | i_no_wb;
        end
      end
      ST_MUL: begin
        o_mul_busy = 1'b1;
        if (mul_cnt_reg == 4'd0) begin
          o_rf_we    = 1'b1;
          o_flags_we = i_set;
          retire     = 1'b1;
          state_next = ST_FETCH;
        end else begin
          mul_cnt_next = mul_cnt_reg - 4'd1;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = i_is_store;
        if (mem_ack) begin
          if (i_is_store) begin
            retire     = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        o_rf_we    = 1'b1;
        retire     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_TRAP: begin
        o_swi_trap = 1'b1;
        o_pc_load  = 1'b1;
        o_link_we  = 1'b1;
        retire     = 1'b1;
        state_next = ST_FETCH;
      end
      default: state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_FETCH;
      mul_cnt_reg <= 4'd0;
      retired_reg <= '0;
    end else begin
      state_reg   <= state_next;
      mul_cnt_reg <= mul_cnt_next;
      if (retire) retired_reg <= retired_reg + CNT_W'(1);
    end
  end

  assign o_state   = state_reg;
  assign o_retired = retired_reg;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: table of instructions with a scoreboard of expected
// per-instruction strobe counts, plus reset, MUL_CYCLES=1 and counter-wrap sequences.
`timescale 1ns/1ps
module tb_cpu_sequencer;

  localparam int MULC = 4;
  localparam int C_DP = 0, C_BR = 1, C_MUL = 2, C_LD = 3, C_ST = 4, C_SWI = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ack0, ack1;
  logic [3:0] i_cond, i_flags;
  logic       i_is_mem, i_is_store, i_is_branch, i_is_link, i_is_mul, i_is_swi, i_no_wb, i_set;

  logic d0_req, d0_we, d0_sel, d0_ir, d0_pcinc, d0_pcl, d0_alu, d0_busy, d0_rf, d0_lnk, d0_fl, d0_trap;
  logic [2:0]  d0_state;
  logic [31:0] d0_ret;
  logic d1_req, d1_we, d1_sel, d1_ir, d1_pcinc, d1_pcl, d1_alu, d1_busy, d1_rf, d1_lnk, d1_fl, d1_trap;
  logic [2:0]  d1_state;
  logic [1:0]  d1_ret;

  cpu_sequencer #(.MUL_CYCLES(MULC), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .mem_ack(ack0), .mem_req(d0_req), .mem_we(d0_we), .mem_sel(d0_sel),
    .i_cond(i_cond), .i_flags(i_flags), .i_is_mem(i_is_mem), .i_is_store(i_is_store),
    .i_is_branch(i_is_branch), .i_is_link(i_is_link), .i_is_mul(i_is_mul), .i_is_swi(i_is_swi),
    .i_no_wb(i_no_wb), .i_set(i_set), .o_ir_load(d0_ir), .o_pc_inc(d0_pcinc), .o_pc_load(d0_pcl),
    .o_alu_en(d0_alu), .o_mul_busy(d0_busy), .o_rf_we(d0_rf), .o_link_we(d0_lnk),
    .o_flags_we(d0_fl), .o_swi_trap(d0_trap), .o_state(d0_state), .o_retired(d0_ret)
  );

  cpu_sequencer #(.MUL_CYCLES(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .mem_ack(ack1), .mem_req(d1_req), .mem_we(d1_we), .mem_sel(d1_sel),
    .i_cond(i_cond), .i_flags(i_flags), .i_is_mem(i_is_mem), .i_is_store(i_is_store),
    .i_is_branch(i_is_branch), .i_is_link(i_is_link), .i_is_mul(i_is_mul), .i_is_swi(i_is_swi),
    .i_no_wb(i_no_wb), .i_set(i_set), .o_ir_load(d1_ir), .o_pc_inc(d1_pcinc), .o_pc_load(d1_pcl),
    .o_alu_en(d1_alu), .o_mul_busy(d1_busy), .o_rf_we(d1_rf), .o_link_we(d1_lnk),
    .o_flags_we(d1_fl), .o_swi_trap(d1_trap), .o_state(d1_state), .o_retired(d1_ret)
  );

  typedef struct {
    string      name;
    int         cls;
    logic [3:0] cond;
    logic [3:0] flags;
    logic       set, no_wb, link, prio, stray;
    int         fa, ma;
    logic       pass;
  } vec_t;

  typedef struct {
    int cycles, ir, pcinc, alu, rf, fl, pcl, lnk, trap, busy, rfbusy, req, sel, we, ret;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_retired = 0;

  task automatic chk(input string n, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", n, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string name, input int cls, input logic [3:0] cond,
                              input logic [3:0] flags, input logic set, input logic no_wb,
                              input logic link, input logic prio, input logic stray,
                              input int fa, input int ma, input logic pass);
    vec_t v;
    v.name = name; v.cls = cls; v.cond = cond; v.flags = flags; v.set = set; v.no_wb = no_wb;
    v.link = link; v.prio = prio; v.stray = stray; v.fa = fa; v.ma = ma; v.pass = pass;
    return v;
  endfunction

  // Expected per-instruction activity, written from the sequencer's timing rules.
  function automatic exp_t model(input vec_t v);
    exp_t e = '{default: 0};
    e.ir = 1; e.pcinc = 1; e.req = v.fa + 1;
    if (!v.pass) begin
      e.cycles = v.fa + 2;
      return e;
    end
    e.ret = 1;
    case (v.cls)
      C_DP:  begin e.cycles = v.fa + 3; e.alu = 1; e.rf = v.no_wb ? 0 : 1; e.fl = (v.set | v.no_wb) ? 1 : 0; end
      C_BR:  begin e.cycles = v.fa + 3; e.pcl = 1; e.lnk = v.link ? 1 : 0; end
      C_MUL: begin e.cycles = v.fa + 2 + MULC; e.busy = MULC; e.rf = 1; e.rfbusy = 1; e.fl = v.set ? 1 : 0; end
      C_LD:  begin e.cycles = v.fa + v.ma + 4; e.rf = 1; e.req += v.ma + 1; e.sel = v.ma + 1; end
      C_ST:  begin e.cycles = v.fa + v.ma + 3; e.req += v.ma + 1; e.sel = v.ma + 1; e.we = v.ma + 1; end
      default: begin e.cycles = v.fa + 3; e.trap = 1; e.pcl = 1; e.lnk = 1; end
    endcase
    return e;
  endfunction

  task automatic drive_instr(input vec_t v);
    i_cond      = v.cond;
    i_flags     = v.flags;
    i_set       = v.set;
    i_no_wb     = v.no_wb;
    i_is_link   = v.link;
    i_is_swi    = (v.cls == C_SWI);
    i_is_branch = (v.cls == C_BR)  || (v.prio && v.cls == C_SWI);
    i_is_mul    = (v.cls == C_MUL) || (v.prio && (v.cls == C_SWI || v.cls == C_BR));
    i_is_mem    = (v.cls == C_LD) || (v.cls == C_ST) ||
                  (v.prio && (v.cls == C_SWI || v.cls == C_BR || v.cls == C_MUL));
    i_is_store  = (v.cls == C_ST);
  endtask

  task automatic run(input vec_t v);
    exp_t e, a;
    int   wf, wm;
    bit   left, done;
    a = '{default: 0};
    wf = 0; wm = 0; left = 0; done = 0;
    drive_instr(v);
    sb.push_back(model(v));
    while (!done && a.cycles < 40) begin
      if (d0_state == 3'd0)      ack0 = (wf >= v.fa);
      else if (d0_state == 3'd4) ack0 = (wm >= v.ma);
      else                       ack0 = v.stray;
      #1;
      a.ir += d0_ir; a.pcinc += d0_pcinc; a.alu += d0_alu; a.rf += d0_rf; a.fl += d0_fl;
      a.pcl += d0_pcl; a.lnk += d0_lnk; a.trap += d0_trap; a.busy += d0_busy;
      a.rfbusy += (d0_rf & d0_busy); a.req += d0_req; a.sel += d0_sel; a.we += d0_we;
      if (d0_state == 3'd0) wf++;
      if (d0_state == 3'd4) wm++;
      a.cycles++;
      @(posedge clk);
      #1;
      if (d0_state == 3'd0 && left) done = 1;
      if (d0_state != 3'd0) left = 1;
    end
    ack0 = 1'b0;
    chk({v.name, ".finished"}, done, 1);
    e = sb.pop_front();
    exp_retired += e.ret;
    chk({v.name, ".cycles"},   a.cycles, e.cycles);
    chk({v.name, ".ir_load"},  a.ir,     e.ir);
    chk({v.name, ".pc_inc"},   a.pcinc,  e.pcinc);
    chk({v.name, ".alu_en"},   a.alu,    e.alu);
    chk({v.name, ".rf_we"},    a.rf,     e.rf);
    chk({v.name, ".flags_we"}, a.fl,     e.fl);
    chk({v.name, ".pc_load"},  a.pcl,    e.pcl);
    chk({v.name, ".link_we"},  a.lnk,    e.lnk);
    chk({v.name, ".swi_trap"}, a.trap,   e.trap);
    chk({v.name, ".mul_busy"}, a.busy,   e.busy);
    chk({v.name, ".mul_wb"},   a.rfbusy, e.rfbusy);
    chk({v.name, ".mem_req"},  a.req,    e.req);
    chk({v.name, ".mem_sel"},  a.sel,    e.sel);
    chk({v.name, ".mem_we"},   a.we,     e.we);
    chk({v.name, ".retired"},  d0_ret,   exp_retired);
    $display("TXN %s cycles=%0d retired=%0d", v.name, a.cycles, d0_ret);
  endtask

  task automatic chk_reset_state(input string n);
    chk({n, ".state"},   d0_state, 0);
    chk({n, ".mem_req"}, d0_req,   1);
    chk({n, ".mem_sel"}, d0_sel,   0);
    chk({n, ".mem_we"},  d0_we,    0);
    chk({n, ".retired"}, d0_ret,   0);
    chk({n, ".strobes"}, {d0_ir, d0_pcinc, d0_pcl, d0_alu, d0_busy, d0_rf, d0_lnk, d0_fl, d0_trap}, 0);
  endtask

  initial begin
    int  guard;
    vec_t ldr;

    rst = 1'b1; ack0 = 1'b0; ack1 = 1'b0;
    i_cond = 4'b1110; i_flags = 4'b0000; i_is_mem = 0; i_is_store = 0; i_is_branch = 0;
    i_is_link = 0; i_is_mul = 0; i_is_swi = 0; i_no_wb = 0; i_set = 0;
    step(); step();
    rst = 1'b0;
    #1;
    chk_reset_state("reset");
    $display("TXN reset state=%0d retired=%0d", d0_state, d0_ret);

    //            name        cls    cond     flags    set no_wb lnk prio stray fa ma pass
    vecs.push_back(mk("add_al",   C_DP,  4'b1110, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("adds_eq",  C_DP,  4'b0000, 4'b0100, 1, 0, 0, 0, 1, 2, 0, 1));
    vecs.push_back(mk("cmp_ne",   C_DP,  4'b0001, 4'b0000, 0, 1, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk("ldr_wait", C_LD,  4'b1110, 4'b0000, 0, 0, 0, 0, 0, 0, 3, 1));
    vecs.push_back(mk("ldr_zw",   C_LD,  4'b1110, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk("str_fw",   C_ST,  4'b1110, 4'b0000, 0, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk("str_zw",   C_ST,  4'b1110, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("str_wait", C_ST,  4'b1110, 4'b0000, 0, 0, 0, 0, 1, 0, 2, 1));
    vecs.push_back(mk("beq_z0",   C_BR,  4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("beq_z1",   C_BR,  4'b0000, 4'b0100, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("mlas",     C_MUL, 4'b1110, 4'b0000, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("mul",      C_MUL, 4'b1110, 4'b0000, 0, 0, 0, 0, 1, 1, 0, 1));
    vecs.push_back(mk("bl",       C_BR,  4'b1110, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk("swi",      C_SWI, 4'b1110, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("swi_prio", C_SWI, 4'b1110, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk("br_prio",  C_BR,  4'b1110, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk("mul_prio", C_MUL, 4'b1110, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk("swi_eq_f", C_SWI, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("ne_f",     C_DP,  4'b0001, 4'b0100, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("cs_t",     C_DP,  4'b0010, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("cc_f",     C_DP,  4'b0011, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("mi_t",     C_DP,  4'b0100, 4'b1000, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("pl_f",     C_DP,  4'b0101, 4'b1000, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("vs_t",     C_DP,  4'b0110, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("vc_t",     C_DP,  4'b0111, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("hi_f",     C_DP,  4'b1000, 4'b0110, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("hi_t",     C_DP,  4'b1000, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("ls_f",     C_DP,  4'b1001, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("ge_t",     C_DP,  4'b1010, 4'b1001, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("lt_t",     C_DP,  4'b1011, 4'b1000, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("gt_t",     C_DP,  4'b1100, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("gt_f",     C_DP,  4'b1100, 4'b1000, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("le_t",     C_DP,  4'b1101, 4'b0100, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("nv_f",     C_DP,  4'b1111, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[k]) run(vecs[k]);
    chk("sb_empty", sb.size(), 0);

    // Reset held two cycles while a load waits in MEM with mem_ack high.
    ldr = mk("ldr_rst", C_LD, 4'b1110, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1);
    drive_instr(ldr);
    ack0 = 1'b1;
    guard = 0;
    while (d0_state != 3'd4 && guard < 10) begin
      step();
      if (d0_state == 3'd1) ack0 = 1'b0;
      guard++;
    end
    chk("rst_mem.reached_mem", d0_state, 4);
    rst = 1'b1; ack0 = 1'b1;
    step(); step();
    rst = 1'b0; ack0 = 1'b0;
    #1;
    chk_reset_state("rst_mem");
    exp_retired = 0;
    $display("TXN rst_mid_mem state=%0d retired=%0d", d0_state, d0_ret);

    // MUL_CYCLES=1 instance: single MUL cycle writes back; 2-bit counter wraps.
    drive_instr(mk("mul1", C_MUL, 4'b1110, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1));
    ack1 = 1'b1;
    #1;
    chk("mul1.fetch_ir", d1_ir, 1);
    step(); ack1 = 1'b0;
    chk("mul1.decode", d1_state, 1);
    step();
    #1;
    chk("mul1.state",  d1_state, 3);
    chk("mul1.busy",   d1_busy,  1);
    chk("mul1.rf_we",  d1_rf,    1);
    step();
    chk("mul1.back",    d1_state, 0);
    chk("mul1.retired", d1_ret,   1);
    $display("TXN mul1 retired=%0d", d1_ret);
    drive_instr(mk("dp1", C_DP, 4'b1110, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 4; k++) begin
      ack1 = 1'b1;
      step(); ack1 = 1'b0;
      step();
      #1;
      chk("wrap.exec_rf", d1_rf, 1);
      step();
      chk("wrap.retired", d1_ret, (k + 2) % 4);
      $display("TXN wrap_dp%0d retired=%0d", k, d1_ret);
    end
    chk("dut0_idle.retired", d0_ret, exp_retired);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control FSM for the ARM core.
- Fetches an instruction over a req/ack memory port.
- Evaluates the condition field against NZCV and routes each instruction through execute, multiply, memory or trap states.
- Sits between the instruction decoder outputs, the register file, ALU/multiplier, PC logic and memory interface.
- Emits one-cycle enable strobes and keeps a retired-instruction counter.

Parameters:
- MUL_CYCLES, 4, cycles spent in MUL state (legal range 1..16).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_ack  in  1  memory completes current request this cycle.
- mem_req  out  1  memory request valid.
- mem_we  out  1  request is a write (store).
- mem_sel  out  1  0 = instruction fetch, 1 = data access.
- i_cond  in  4  condition field of latched instruction.
- i_flags  in  4  current NZCV ({N,Z,C,V}).
- i_is_mem  in  1  ldr/str/swp class.
- i_is_store  in  1  store (valid only when i_is_mem).
- i_is_branch  in  1  b/bl.
- i_is_link  in  1  bl.
- i_is_mul  in  1  mul/mla.
- i_is_swi  in  1  software interrupt.
- i_no_wb  in  1  cmp/cmn/tst/teq; no register write.
- i_set  in  1  S bit.
- o_ir_load  out  1  latch instruction register.
- o_pc_inc  out  1  PC += 4.
- o_pc_load  out  1  PC <= branch/vector target.
- o_alu_en  out  1  ALU operates this cycle.
- o_mul_busy  out  1  multiplier active.
- o_rf_we  out  1  register file write.
- o_link_we  out  1  write r14.
- o_flags_we  out  1  update NZCV.
- o_swi_trap  out  1  SWI vector taken.
- o_state  out  3  current state encoding.
- o_retired  out  CNT_W  count of executed (condition-passed) instructions.

Behaviour:
States and encodings: FETCH=0, DECODE=1, EXEC=2, MUL=3, MEM=4, WB=5, TRAP=6. Encoding 7 is unused and recovers to FETCH.

Reset (rst=1 at edge):
- State goes to FETCH; mul counter and o_retired go to 0.
- rst overrides any in-flight request; an outstanding mem_ack is ignored.
- Outputs in the cycle after reset: mem_req=1, mem_sel=0, mem_we=0. All strobes are 0.

All decoder inputs are stable from DECODE until the instruction retires, because the IR is held.

FETCH:
- mem_req=1, mem_sel=0, mem_we=0.
- Hold while mem_ack=0.
- On mem_ack=1: o_ir_load=1 and o_pc_inc=1 in the same cycle, then go to DECODE.

DECODE (exactly 1 cycle):
- Compute pass from i_cond and i_flags using the ARM table: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL=1110 always. 1111 is never.
- !pass: go to FETCH; o_retired unchanged.
- Otherwise, with priority swi > branch > mul > mem > data-processing:
  - swi → TRAP.
  - branch → EXEC.
  - mul → MUL.
  - mem → MEM.
  - data-processing → EXEC.

EXEC (1 cycle), then FETCH; o_retired += 1.
- Data-processing:
  - o_alu_en=1.
  - o_rf_we = !i_no_wb.
  - o_flags_we = i_set | i_no_wb.
- Branch:
  - o_pc_load=1.
  - o_link_we = i_is_link.
  - o_rf_we=0, o_flags_we=0.

MUL:
- On entry, counter <= MUL_CYCLES-1. o_mul_busy=1 in every MUL cycle.
- Counter decrements each cycle.
- In the cycle the counter is 0: o_rf_we=1, o_flags_we=i_set, go to FETCH, o_retired += 1.
- Total time in MUL is MUL_CYCLES cycles.

MEM:
- mem_req=1, mem_sel=1, mem_we=i_is_store.
- Hold until mem_ack.
- On ack, a store goes to FETCH with o_retired += 1; a load goes to WB.

WB (1 cycle):
- o_rf_we=1.
- Go to FETCH; o_retired += 1.

TRAP (1 cycle):
- o_swi_trap=1, o_pc_load=1, o_link_we=1.
- Go to FETCH; o_retired += 1.

Output timing:
- All strobes are combinational from state, plus mem_ack in FETCH/MEM and the counter in MUL.
- Strobes are never asserted outside the cases listed above.

Boundary conditions:
- mem_ack while mem_req=0 is ignored.
- mem_ack in the same cycle a request first asserts completes the request (zero-wait memory).
- o_retired wraps from all-ones to 0.
- MUL_CYCLES=1 means MUL lasts one cycle, with o_rf_we in that cycle.
- Minimum instruction latencies: data-processing 3, load 4, store 3 (all with zero-wait memory).

Decomposition:
- Shared package cpu_pkg holds:
  - state enum (typedef cpu_state_t).
  - condition-code constants COND_EQ..COND_NV.
  - NZCV bit-index constants.
- Sub-module cond_check (i_cond, i_flags → pass), purely combinational. It is reused by any later pipelined control.

Test Plan:
- rst held 2 cycles mid-MEM with mem_ack=1 → next cycle state=0, mem_req=1, mem_sel=0, o_retired=0, no o_rf_we.
- ADD, AL, i_set=0, zero-wait memory → states 0,1,2,0; o_rf_we=1 only in EXEC; o_flags_we=0; o_retired=1.
- LDR with mem_ack delayed 3 cycles in MEM → mem_req=1, mem_sel=1, mem_we=0 for 4 cycles; WB asserts o_rf_we once; o_retired=1.
- BEQ with i_flags=4'b0000 → DECODE returns to FETCH; no o_pc_load; o_retired unchanged. Repeat with Z=1 → o_pc_load=1 in EXEC.
- MLA with MUL_CYCLES=4, i_set=1 → o_mul_busy high for exactly 4 cycles; o_rf_we and o_flags_we only in the 4th.
- BL, then SWI → BL: o_pc_load=1 and o_link_we=1 in EXEC. SWI: o_swi_trap=1, o_pc_load=1, o_link_we=1 in TRAP; o_retired=2.
